// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 execute/memory datapath: opcodes, funct fields,
// ALU operations, operand/write-back source selects and the decoded control bundle.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_BYTE   = 3'b000;
   localparam logic [2:0] F3_HALF   = 3'b001;
   localparam logic [2:0] F3_WORD   = 3'b010;
   localparam logic [2:0] F3_BYTE_U = 3'b100;
   localparam logic [2:0] F3_HALF_U = 3'b101;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRC_IMM_I = 2'b00;
   localparam logic [1:0] SRC_IMM_S = 2'b01;
   localparam logic [1:0] SRC_RS2   = 2'b10;

   localparam logic [1:0] WB_IMM_U = 2'b00;
   localparam logic [1:0] WB_ALU   = 2'b01;
   localparam logic [1:0] WB_MEM   = 2'b10;

   typedef struct packed {
      logic       reg_we;
      logic       mem_we;
      logic [1:0] alu_src;
      logic [1:0] wb_src;
      logic [2:0] alu_op;
   } ctrl_t;

   // Returns {legal, alu_op} for the arithmetic funct3 map shared by OP and OP-IMM.
   function automatic logic [3:0] f3_to_alu(input logic [2:0] funct3);
      case (funct3)
         F3_ADD:  return {1'b1, ALU_ADD};
         F3_SLT:  return {1'b1, ALU_SLT};
         F3_OR:   return {1'b1, ALU_OR};
         F3_AND:  return {1'b1, ALU_AND};
         default: return {1'b0, ALU_ADD};
      endcase
   endfunction

endpackage

// File: rtl/arithmetic_logic_unit.sv
// 32-bit integer ALU with a zero flag; shared by the execute stage and the PC incrementer.
module arithmetic_logic_unit
   import riscv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic        [2:0]        i_alu_op,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   output logic signed [DATA_W-1:0] o_result,
   output logic                     o_zero
);

   always_comb begin
      case (i_alu_op)
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_ADD: o_result = i_a + i_b;
         ALU_SUB: o_result = i_a - i_b;
         // Both operands are declared signed, so this is a signed compare.
         ALU_SLT: o_result = (i_a < i_b) ? DATA_W'(1) : '0;
         default: o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/riscv_execute_memory_stage.sv
// Single-cycle RV32 execute stage: control decode, ALU, byte-addressed data memory
// and write-back selection. Only the memory array is clocked.
module riscv_execute_memory_stage
   import riscv_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [31:0] imm_i_i,
   input  logic [31:0] imm_s_i,
   input  logic [31:0] imm_u_i,
   output logic        reg_write_enable_o,
   output logic [31:0] reg_write_data_o,
   output logic [31:0] alu_result_o,
   output logic        alu_zero_o,
   output logic        mem_write_enable_o
);

   localparam int AW = $clog2(MEM_WORDS);

   ctrl_t               w_ctrl;
   logic                w_f3_legal;
   logic        [2:0]   w_f3_op;
   logic signed [31:0]  w_alu_a;
   logic signed [31:0]  w_alu_b;
   logic signed [31:0]  w_alu_result;
   logic                w_alu_zero;
   logic        [AW-1:0] w_idx;
   logic        [3:0]   w_be;
   logic        [31:0]  w_wdata;
   logic        [31:0]  w_rd_word;
   logic        [7:0]   w_rd_byte;
   logic        [15:0]  w_rd_half;
   logic        [31:0]  w_load;

   logic [31:0] r_mem [MEM_WORDS];

   assign {w_f3_legal, w_f3_op} = f3_to_alu(funct3_i);

   always_comb begin
      w_ctrl = '{reg_we: 1'b0, mem_we: 1'b0, alu_src: SRC_IMM_I, wb_src: WB_ALU, alu_op: ALU_ADD};
      case (opcode_i)
         OPC_LOAD: begin
            w_ctrl.reg_we = 1'b1;
            w_ctrl.wb_src = WB_MEM;
         end
         OPC_STORE: begin
            w_ctrl.mem_we  = 1'b1;
            w_ctrl.alu_src = SRC_IMM_S;
         end
         OPC_LUI: begin
            w_ctrl.reg_we = 1'b1;
            w_ctrl.wb_src = WB_IMM_U;
         end
         OPC_OP_IMM: begin
            if (w_f3_legal) begin
               w_ctrl.reg_we = 1'b1;
               w_ctrl.alu_op = w_f3_op;
            end
         end
         OPC_OP: begin
            if (w_f3_legal && (funct7_i == F7_BASE || funct7_i == F7_ALT)) begin
               w_ctrl.reg_we  = 1'b1;
               w_ctrl.alu_src = SRC_RS2;
               w_ctrl.alu_op  = (funct7_i == F7_ALT && funct3_i == F3_ADD) ? ALU_SUB : w_f3_op;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (w_ctrl.alu_src)
         SRC_IMM_I: w_alu_b = imm_i_i;
         SRC_IMM_S: w_alu_b = imm_s_i;
         SRC_RS2:   w_alu_b = rs2_data_i;
         default:   w_alu_b = '0;
      endcase
   end

   assign w_alu_a = rs1_data_i;

   arithmetic_logic_unit #(.DATA_W(32)) u_alu (
      .i_alu_op (w_ctrl.alu_op),
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .o_result (w_alu_result),
      .o_zero   (w_alu_zero)
   );

   // Upper address bits are dropped so accesses wrap around the array.
   assign w_idx = w_alu_result[AW+1:2];

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = rs2_data_i;
      case (funct3_i)
         F3_BYTE: begin
            w_be    = 4'b0001 << w_alu_result[1:0];
            w_wdata = {4{rs2_data_i[7:0]}};
         end
         F3_HALF: begin
            w_be    = w_alu_result[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{rs2_data_i[15:0]}};
         end
         F3_WORD: w_be = 4'b1111;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         for (int k = 0; k < MEM_WORDS; k++) r_mem[k] <= '0;
      end else if (w_ctrl.mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   assign w_rd_word = r_mem[w_idx];

   always_comb begin
      case (w_alu_result[1:0])
         2'd0:    w_rd_byte = w_rd_word[7:0];
         2'd1:    w_rd_byte = w_rd_word[15:8];
         2'd2:    w_rd_byte = w_rd_word[23:16];
         default: w_rd_byte = w_rd_word[31:24];
      endcase
      w_rd_half = w_alu_result[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (funct3_i)
         F3_BYTE:   w_load = {{24{w_rd_byte[7]}}, w_rd_byte};
         F3_HALF:   w_load = {{16{w_rd_half[15]}}, w_rd_half};
         F3_WORD:   w_load = w_rd_word;
         F3_BYTE_U: w_load = {24'd0, w_rd_byte};
         F3_HALF_U: w_load = {16'd0, w_rd_half};
         default:   w_load = '0;
      endcase
   end

   always_comb begin
      case (w_ctrl.wb_src)
         WB_IMM_U: reg_write_data_o = imm_u_i;
         WB_ALU:   reg_write_data_o = w_alu_result;
         WB_MEM:   reg_write_data_o = w_load;
         default:  reg_write_data_o = '0;
      endcase
   end

   assign reg_write_enable_o = w_ctrl.reg_we;
   assign mem_write_enable_o = w_ctrl.mem_we;
   assign alu_result_o       = w_alu_result;
   assign alu_zero_o         = w_alu_zero;

endmodule

// File: tb/tb_riscv_execute_memory_stage.sv
// Bench for riscv_execute_memory_stage: decode/ALU vector table, memory sequences,
// and randomized instructions against a byte-array instruction-level model.
module tb_riscv_execute_memory_stage;

   localparam int MEM_WORDS = 256;
   localparam int MEM_BYTES = MEM_WORDS * 4;
   localparam int AB        = $clog2(MEM_BYTES);

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] OPI   = 7'b0010011;
   localparam logic [6:0] OP    = 7'b0110011;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] rs1, rs2, imm_i, imm_s, imm_u;
   logic        rwe, zero, mwe;
   logic [31:0] wd, alu;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m [MEM_BYTES];

   always #5 clk = ~clk;

   riscv_execute_memory_stage #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk_i              (clk),
      .reset_i            (reset_i),
      .opcode_i           (opcode),
      .funct3_i           (funct3),
      .funct7_i           (funct7),
      .rs1_data_i         (rs1),
      .rs2_data_i         (rs2),
      .imm_i_i            (imm_i),
      .imm_s_i            (imm_s),
      .imm_u_i            (imm_u),
      .reg_write_enable_o (rwe),
      .reg_write_data_o   (wd),
      .alu_result_o       (alu),
      .alu_zero_o         (zero),
      .mem_write_enable_o (mwe)
   );

   typedef struct packed {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ii;
      logic [31:0] iu;
      logic        e_rwe;
      logic        e_mwe;
      logic        chk_wd;
      logic [31:0] e_wd;
      logic        chk_alu;
      logic [31:0] e_alu;
   } vec_t;

   vec_t vt [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ii, input logic [31:0] is, input logic [31:0] iu);
      @(negedge clk);
      reset_i = rst; opcode = opc; funct3 = f3; funct7 = f7;
      rs1 = a; rs2 = b; imm_i = ii; imm_s = is; imm_u = iu;
      #1;
   endtask

   function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] addr);
      int a, h, w;
      a = int'(addr[AB-1:0]);
      h = a - (a % 2);
      w = a - (a % 4);
      case (f3)
         3'b000:  return {{24{m[a][7]}}, m[a]};
         3'b100:  return {24'd0, m[a]};
         3'b001:  return {{16{m[h+1][7]}}, m[h+1], m[h]};
         3'b101:  return {16'd0, m[h+1], m[h]};
         3'b010:  return {m[w+3], m[w+2], m[w+1], m[w]};
         default: return 32'd0;
      endcase
   endfunction

   task automatic mstore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      int a, h, w;
      a = int'(addr[AB-1:0]);
      h = a - (a % 2);
      w = a - (a % 4);
      case (f3)
         3'b000: m[a] = data[7:0];
         3'b001: begin m[h] = data[7:0]; m[h+1] = data[15:8]; end
         3'b010: for (int k = 0; k < 4; k++) m[w+k] = data[8*k +: 8];
         default: ;
      endcase
   endtask

   initial begin
      int          kind;
      logic [6:0]  r_opc, r_f7;
      logic [2:0]  r_f3;
      logic [31:0] r_a, r_b, r_ii, r_is, r_iu, r_opb, addr;
      logic        e_rwe, e_mwe, c_wd, c_alu, legal;
      logic [31:0] e_wd, e_alu;

      reset_i = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
      rs1 = '0; rs2 = '0; imm_i = '0; imm_s = '0; imm_u = '0;

      vt[0]  = '{OP,  3'b000, 7'h20, 32'd5,        32'd7,        32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE};
      vt[1]  = '{OPI, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd0,        32'd1,        32'd0, 1'b1, 1'b0, 1'b1, 32'd1,        1'b1, 32'd1};
      vt[2]  = '{OP,  3'b111, 7'h00, 32'h0000F0F0, 32'h00000FF0, 32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'h000000F0, 1'b1, 32'h000000F0};
      vt[3]  = '{LUI, 3'b000, 7'h00, 32'd0,        32'd0,        32'd0, 32'h12345000, 1'b1, 1'b0, 1'b1, 32'h12345000, 1'b0, 32'd0};
      vt[4]  = '{7'h7F, 3'b000, 7'h00, 32'd1,      32'd2,        32'd3,        32'd0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0};
      vt[5]  = '{OP,  3'b000, 7'h00, 32'd7,        32'hFFFFFFF9, 32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'd0,        1'b1, 32'd0};
      vt[6]  = '{OP,  3'b110, 7'h00, 32'hA0000000, 32'd5,        32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'hA0000005, 1'b1, 32'hA0000005};
      vt[7]  = '{OP,  3'b010, 7'h00, 32'h80000000, 32'd1,        32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'd1,        1'b1, 32'd1};
      vt[8]  = '{OP,  3'b010, 7'h00, 32'd1,        32'h80000000, 32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'd0,        1'b1, 32'd0};
      vt[9]  = '{OP,  3'b000, 7'h01, 32'd3,        32'd4,        32'd0,        32'd0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0};
      vt[10] = '{OPI, 3'b001, 7'h00, 32'd3,        32'd0,        32'd1,        32'd0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0};
      vt[11] = '{OPI, 3'b000, 7'h00, 32'h7FFFFFFF, 32'd0,        32'd1,        32'd0, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b1, 32'h80000000};
      vt[12] = '{OPI, 3'b111, 7'h00, 32'h12345678, 32'd0,        32'hFFFFF0F0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h12345070, 1'b1, 32'h12345070};
      vt[13] = '{OP,  3'b000, 7'h20, 32'd9,        32'd9,        32'd0,        32'd0, 1'b1, 1'b0, 1'b1, 32'd0,        1'b1, 32'd0};
      vt[14] = '{OPI, 3'b000, 7'h20, 32'd10,       32'd0,        32'd3,        32'd0, 1'b1, 1'b0, 1'b1, 32'd13,       1'b1, 32'd13};
      vt[15] = '{OP,  3'b011, 7'h00, 32'd1,        32'd2,        32'd0,        32'd0, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0};

      // Reset with a simultaneous store: decode still flags the store, memory stays cleared.
      drive(1'b0, STORE, 3'b010, 7'h00, 32'h40, 32'hCAFEBABE, 32'd0, 32'd0, 32'd0);
      chk("rst_mwe", {31'd0, mwe}, 32'd1);
      drive(1'b1, LOAD, 3'b010, 7'h00, 32'h40, 32'd0, 32'd0, 32'd0, 32'd0);
      chk("rst_lw", wd, 32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vt[i].opc, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, vt[i].ii, 32'd0, vt[i].iu);
         chk($sformatf("vec%0d_rwe", i), {31'd0, rwe}, {31'd0, vt[i].e_rwe});
         chk($sformatf("vec%0d_mwe", i), {31'd0, mwe}, {31'd0, vt[i].e_mwe});
         if (vt[i].chk_wd) chk($sformatf("vec%0d_wd", i), wd, vt[i].e_wd);
         if (vt[i].chk_alu) begin
            chk($sformatf("vec%0d_alu", i), alu, vt[i].e_alu);
            chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, (vt[i].e_alu == 32'd0)});
         end
      end

      drive(1'b1, STORE, 3'b010, 7'h00, 32'h100, 32'hDEADBEEF, 32'd0, 32'd4, 32'd0);
      chk("sw_mwe", {31'd0, mwe}, 32'd1);
      chk("sw_rwe", {31'd0, rwe}, 32'd0);
      chk("sw_addr", alu, 32'h104);
      drive(1'b1, LOAD, 3'b010, 7'h00, 32'h100, 32'd0, 32'd4, 32'd0, 32'd0);
      chk("lw_data", wd, 32'hDEADBEEF);
      chk("lw_rwe", {31'd0, rwe}, 32'd1);
      drive(1'b1, LOAD, 3'b000, 7'h00, 32'h104, 32'd0, 32'd3, 32'd0, 32'd0);
      chk("lb3", wd, 32'hFFFFFFDE);
      drive(1'b1, LOAD, 3'b100, 7'h00, 32'h104, 32'd0, 32'd3, 32'd0, 32'd0);
      chk("lbu3", wd, 32'h000000DE);
      drive(1'b1, LOAD, 3'b001, 7'h00, 32'h104, 32'd0, 32'd2, 32'd0, 32'd0);
      chk("lh2", wd, 32'hFFFFDEAD);
      drive(1'b1, LOAD, 3'b101, 7'h00, 32'h104, 32'd0, 32'd0, 32'd0, 32'd0);
      chk("lhu0", wd, 32'h0000BEEF);
      drive(1'b1, STORE, 3'b000, 7'h00, 32'h100, 32'h00000012, 32'd0, 32'd5, 32'd0);
      drive(1'b1, LOAD, 3'b010, 7'h00, 32'h104, 32'd0, 32'd0, 32'd0, 32'd0);
      chk("sb_lw", wd, 32'hDEAD12EF);
      drive(1'b1, STORE, 3'b001, 7'h00, 32'h100, 32'hFFFF8001, 32'd0, 32'd6, 32'd0);
      drive(1'b1, LOAD, 3'b001, 7'h00, 32'h104, 32'd0, 32'd3, 32'd0, 32'd0);
      chk("sh_lh_odd", wd, 32'hFFFF8001);
      drive(1'b1, LOAD, 3'b010, 7'h00, 32'h500, 32'd0, 32'd4, 32'd0, 32'd0);
      chk("lw_wrap", wd, 32'h800112EF);
      drive(1'b1, LOAD, 3'b011, 7'h00, 32'h104, 32'd0, 32'd0, 32'd0, 32'd0);
      chk("ld_bad_f3", wd, 32'd0);
      drive(1'b1, STORE, 3'b011, 7'h00, 32'h104, 32'd0, 32'd0, 32'd0, 32'd0);
      drive(1'b1, LOAD, 3'b010, 7'h00, 32'h104, 32'd0, 32'd0, 32'd0, 32'd0);
      chk("st_bad_f3", wd, 32'h800112EF);
      drive(1'b0, STORE, 3'b010, 7'h00, 32'h104, 32'h11111111, 32'd0, 32'd0, 32'd0);
      drive(1'b1, LOAD, 3'b010, 7'h00, 32'h104, 32'd0, 32'd0, 32'd0, 32'd0);
      chk("midrst_lw", wd, 32'd0);

      // Randomized instructions against the byte-array model; memory is all zero here.
      for (int k = 0; k < MEM_BYTES; k++) m[k] = 8'd0;
      for (int t = 0; t < 400; t++) begin
         kind = int'($urandom_range(0, 5));
         r_a  = ($urandom & 32'hFFFFFC00) | (32'h200 + 32'($urandom_range(0, 63)));
         r_b  = $urandom;
         r_ii = 32'($urandom_range(0, 63)); r_ii = r_ii - 32'd32;
         r_is = 32'($urandom_range(0, 63)); r_is = r_is - 32'd32;
         r_iu = $urandom & 32'hFFFFF000;
         r_f3 = 3'($urandom);
         r_f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
         if ($urandom_range(0, 7) == 0) r_b = r_a;
         e_rwe = 1'b0; e_mwe = 1'b0; c_wd = 1'b0; c_alu = 1'b0; e_wd = '0; e_alu = '0;
         case (kind)
            0: begin
               r_opc = LOAD;
               case ($urandom_range(0, 4))
                  0: r_f3 = 3'b000; 1: r_f3 = 3'b001; 2: r_f3 = 3'b010;
                  3: r_f3 = 3'b100; default: r_f3 = 3'b101;
               endcase
               addr = r_a + r_ii;
               e_rwe = 1'b1; c_alu = 1'b1; e_alu = addr; c_wd = 1'b1; e_wd = mload(r_f3, addr);
            end
            1: begin
               r_opc = STORE;
               r_f3 = 3'($urandom_range(0, 2));
               e_mwe = 1'b1; c_alu = 1'b1; e_alu = r_a + r_is;
            end
            2, 3: begin
               r_opc = (kind == 2) ? OP : OPI;
               r_opb = (kind == 2) ? r_b : r_ii;
               legal = (r_f3 == 3'b000 || r_f3 == 3'b010 || r_f3 == 3'b110 || r_f3 == 3'b111) &&
                       (kind == 3 || r_f7 == 7'h00 || r_f7 == 7'h20);
               if (legal) begin
                  case (r_f3)
                     3'b000:  e_alu = (kind == 2 && r_f7 == 7'h20) ? r_a - r_opb : r_a + r_opb;
                     3'b010:  e_alu = ($signed(r_a) < $signed(r_opb)) ? 32'd1 : 32'd0;
                     3'b110:  e_alu = r_a | r_opb;
                     default: e_alu = r_a & r_opb;
                  endcase
                  e_rwe = 1'b1; c_alu = 1'b1; c_wd = 1'b1; e_wd = e_alu;
               end
            end
            4: begin
               r_opc = LUI;
               e_rwe = 1'b1; c_wd = 1'b1; e_wd = r_iu;
            end
            default: begin
               do r_opc = 7'($urandom);
               while (r_opc == LOAD || r_opc == STORE || r_opc == LUI || r_opc == OPI || r_opc == OP);
            end
         endcase
         drive(1'b1, r_opc, r_f3, r_f7, r_a, r_b, r_ii, r_is, r_iu);
         chk($sformatf("rnd%0d_rwe", t), {31'd0, rwe}, {31'd0, e_rwe});
         chk($sformatf("rnd%0d_mwe", t), {31'd0, mwe}, {31'd0, e_mwe});
         if (c_alu) begin
            chk($sformatf("rnd%0d_alu", t), alu, e_alu);
            chk($sformatf("rnd%0d_zero", t), {31'd0, zero}, {31'd0, (e_alu == 32'd0)});
         end
         if (c_wd) chk($sformatf("rnd%0d_wd", t), wd, e_wd);
         if (kind == 1) mstore(r_f3, r_a + r_is, r_b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_execute_memory_stage.md
# riscv_execute_memory_stage

Combinational execute stage plus byte-addressed data memory for the single-cycle RV32 softcore. It decodes the opcode, funct3 and funct7 into control signals, selects the ALU operand and runs the ALU. It performs loads and stores and selects the register-file write-back value. It sits between the instruction decoder/register file and the register-file write port.

## Interface
- `MEM_WORDS`, default 256: data memory depth in 32-bit words; power of two.
- `clk_i`  in  1  clock; memory writes happen on its rising edge.
- `reset_i`  in  1  reset; synchronous and active-low.
- `opcode_i`  in  7  instruction bits [6:0].
- `funct3_i`  in  3  instruction bits [14:12].
- `funct7_i`  in  7  instruction bits [31:25].
- `rs1_data_i`  in  32  register-file read port 1.
- `rs2_data_i`  in  32  register-file read port 2; this is also the store data.
- `imm_i_i`, `imm_s_i`, `imm_u_i`  in  32 each  sign-extended I, S and U immediates from the decoder.
- `reg_write_enable_o`  out  1  register-file write enable.
- `reg_write_data_o`  out  32  write-back value.
- `alu_result_o`  out  32  ALU result; also the memory address.
- `alu_zero_o`  out  1  high when `alu_result_o` is 0.
- `mem_write_enable_o`  out  1  store is active this cycle.

## Operation
**Control (combinational)**
- LOAD `0000011`: reg_we=1, mem_we=0, ALU source is imm_i, write-back source is memory, ALU op is ADD.
- STORE `0100011`: reg_we=0, mem_we=1, ALU source is imm_s, ALU op is ADD.
- LUI `0110111`: reg_we=1, write-back value is imm_u; ALU source is don't-care and is driven as imm_i.
- OP-IMM `0010011`: reg_we=1, ALU source is imm_i, write-back value is the ALU result.
  - funct3 000=ADD, 111=AND, 110=OR, 010=SLT.
- OP `0110011`: reg_we=1, ALU source is rs2, write-back value is the ALU result.
  - Same funct3 map as OP-IMM.
  - funct3 000 with funct7 `0100000` is SUB.
  - Any funct7 other than `0000000` or `0100000` is illegal.
- Unlisted opcodes and unlisted funct3 values are illegal.
  - Illegal instructions force reg_we=0 and mem_we=0.
  - The ALU op falls back to ADD; data outputs are don't-care.
- The internal 2-bit ALU-source code is 00=imm_i, 01=imm_s, 10=rs2; code 11 yields operand 0.
- The internal 2-bit write-back-source code is 00=imm_u, 01=ALU, 10=memory; code 11 yields 0.

**ALU (3-bit op code)**
- 000=AND, 001=OR, 010=ADD, 110=SUB, 111=SLT (signed; result is 1 or 0).
- Arithmetic is 32-bit modulo 2^32 with no overflow flag.
- Undefined op codes produce 0.

**Data memory**
- Storage is MEM_WORDS x 32 bits, little-endian.
- Word index is address[log2(MEM_WORDS)+1:2]; higher address bits are ignored, so accesses wrap.
- Loads (funct3), read combinationally:
  - 000 LB: sign-extended byte at address[1:0].
  - 001 LH: sign-extended halfword; address[1] selects the half, address[0] is ignored.
  - 010 LW: full word; address[1:0] are ignored.
  - 100 LBU and 101 LHU: zero-extended versions of LB and LH.
  - Any other funct3 returns 0.
- Stores (funct3), using byte enables on the rising clock edge:
  - 000 SB writes rs2[7:0] to the byte at address[1:0].
  - 001 SH writes rs2[15:0] to the half selected by address[1].
  - 010 SW writes the full word.
  - Any other funct3 writes nothing.
- Bytes outside the enabled lanes are preserved.

## Timing
- Every output is combinational from its inputs and memory state; there are no pipeline registers.
- A store commits on the rising edge of `clk_i`. A load from the same address reads the new value in the following cycle.
- Reset, checked at the edge while `reset_i`=0:
  - Every memory word becomes 0 and any store in that cycle is suppressed; reset wins over a simultaneous write.
  - Control and ALU outputs do not depend on reset.
  - `mem_write_enable_o` is still driven by the decode while reset is asserted.
- Reset mid-program clears memory in one edge; normal operation resumes on the first edge with `reset_i`=1.
- The memory contents before the first reset are undefined.

## Structure
- A shared package `riscv_pkg` holds:
  - the opcode constants;
  - the funct3 load/store width constants;
  - the ALU op encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - the ALU-source and write-back-source encodings.
- The ALU is a separate sub-module, `arithmetic_logic_unit`, because the PC incrementer reuses it with op ADD.
- Control decode and the data memory stay inline in this block.

## Test plan
- **Reset:** hold `reset_i`=0 for one edge, release, then LW at 0x40 → `reg_write_data_o`=0x00000000.
- **Word store and load:**
  - SW with rs1=0x100, imm_s=4, rs2=0xDEADBEEF → `mem_write_enable_o`=1 and `alu_result_o`=0x104.
  - Next cycle, LW with rs1=0x100, imm_i=4 → 0xDEADBEEF with reg_we=1.
- **Byte and halfword loads:** after that store, with base 0x104:
  - LB at offset 3 → 0xFFFFFFDE; LBU at offset 3 → 0x000000DE.
  - LH at offset 2 → 0xFFFFDEAD; LHU at offset 0 → 0x0000BEEF.
- **Partial store:** SB of rs2=0x12 to 0x105 → LW 0x104 returns 0xDEAD12EF.
- **Arithmetic:**
  - OP SUB with rs1=5, rs2=7 → 0xFFFFFFFE and zero_o=0.
  - OP-IMM SLTI with rs1=0xFFFFFFFF, imm=1 → 1.
  - OP AND with 0xF0F0 and 0x0FF0 → 0x00F0.
- **Misc decode:**
  - LUI with imm_u=0x12345000 → write data 0x12345000, reg_we=1.
  - Opcode `1111111` → reg_we=0 and mem_we=0.
  - SW issued while `reset_i`=0 → memory still reads 0 after reset is released.
